// File: rtl/enhanced_stopwatch.sv
// enhanced_stopwatch: m.ss.d BCD stopwatch with up/down counting and a 0.1 s prescaler.
// Define ENHANCED_STOPWATCH_WRAP_EN to wrap at 9.59.9/0.00.0 instead of saturating.
module enhanced_stopwatch #(
    parameter int DVSR = 9999999
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic       clr,
    input  logic       up,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0
);
    localparam logic [26:0] TC = 27'(DVSR);
    logic [26:0] cnt;
    logic        tick;
    logic        at_max;
    logic        at_min;
    logic        hold;
    logic        c0, c1, c2;
    logic        b0, b1, b2;
    logic [3:0]  u3, u2, u1, u0;
    logic [3:0]  w3, w2, w1, w0;
    logic [3:0]  n3, n2, n1, n0;
    assign tick   = go && cnt == TC;
    assign at_max = d3 == 4'd9 && d2 == 4'd5 && d1 == 4'd9 && d0 == 4'd9;
    assign at_min = d3 == 4'd0 && d2 == 4'd0 && d1 == 4'd0 && d0 == 4'd0;
`ifdef ENHANCED_STOPWATCH_WRAP_EN
    assign hold = 1'b0;
`else
    assign hold = up ? at_max : at_min;
`endif
    // Ripple carry/borrow chains; the wrap values fall out naturally at the range ends.
    always_comb begin
        c0 = d0 == 4'd9;
        c1 = c0 && d1 == 4'd9;
        c2 = c1 && d2 == 4'd5;
        u0 = c0 ? 4'd0 : d0 + 4'd1;
        u1 = c0 ? (d1 == 4'd9 ? 4'd0 : d1 + 4'd1) : d1;
        u2 = c1 ? (d2 == 4'd5 ? 4'd0 : d2 + 4'd1) : d2;
        u3 = c2 ? (d3 == 4'd9 ? 4'd0 : d3 + 4'd1) : d3;
        b0 = d0 == 4'd0;
        b1 = b0 && d1 == 4'd0;
        b2 = b1 && d2 == 4'd0;
        w0 = b0 ? 4'd9 : d0 - 4'd1;
        w1 = b0 ? (d1 == 4'd0 ? 4'd9 : d1 - 4'd1) : d1;
        w2 = b1 ? (d2 == 4'd0 ? 4'd5 : d2 - 4'd1) : d2;
        w3 = b2 ? (d3 == 4'd0 ? 4'd9 : d3 - 4'd1) : d3;
        n0 = hold ? d0 : (up ? u0 : w0);
        n1 = hold ? d1 : (up ? u1 : w1);
        n2 = hold ? d2 : (up ? u2 : w2);
        n3 = hold ? d3 : (up ? u3 : w3);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            {d3, d2, d1, d0} <= '0;
        end else if (clr) begin
            cnt <= '0;
            {d3, d2, d1, d0} <= '0;
        end else if (go) begin
            cnt <= tick ? 27'd0 : cnt + 27'd1;
            if (tick)
                {d3, d2, d1, d0} <= {n3, n2, n1, n0};
        end
    end
endmodule

// File: tb/tb_enhanced_stopwatch.sv
// tb_enhanced_stopwatch: directed checks of two stopwatches (DVSR=0 and DVSR=4).
module tb_enhanced_stopwatch;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic go0 = 1'b0, clr0 = 1'b0, up0 = 1'b1;
    logic go4 = 1'b0, clr4 = 1'b0, up4 = 1'b1;
    logic [3:0] a3, a2, a1, a0;
    logic [3:0] b3, b2, b1, b0;
    int n_vec = 0;
    int n_err = 0;

    enhanced_stopwatch #(.DVSR(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .go(go0), .clr(clr0), .up(up0),
        .d3(a3), .d2(a2), .d1(a1), .d0(a0)
    );
    enhanced_stopwatch #(.DVSR(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .go(go4), .clr(clr4), .up(up4),
        .d3(b3), .d2(b2), .d1(b1), .d0(b0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        step(2);
        chk("reset_dut0", {a3, a2, a1, a0}, 16'h0000);
        chk("reset_dut4", {b3, b2, b1, b0}, 16'h0000);
        reset_n = 1'b1;
        // DVSR=4 prescaler behaviour
        go4 = 1'b1;
        step(15);
        chk("dvsr4_15clk", {b3, b2, b1, b0}, 16'h0003);
        chk("dut0_idle", {a3, a2, a1, a0}, 16'h0000);
        clr4 = 1'b1;
        step(1);
        chk("dvsr4_clr", {b3, b2, b1, b0}, 16'h0000);
        clr4 = 1'b0;
        step(2);
        go4 = 1'b0;
        step(10);
        chk("dvsr4_paused", {b3, b2, b1, b0}, 16'h0000);
        go4 = 1'b1;
        step(2);
        chk("dvsr4_resume2", {b3, b2, b1, b0}, 16'h0000);
        step(1);
        chk("dvsr4_resume3", {b3, b2, b1, b0}, 16'h0001);
        go4 = 1'b0;
        // DVSR=0: one tick per enabled clock
        go0 = 1'b1;
        step(200);
        go0 = 1'b0;
        chk("up_200", {a3, a2, a1, a0}, 16'h0200);
        step(50);
        chk("hold_50", {a3, a2, a1, a0}, 16'h0200);
        go0 = 1'b1;
        step(399);
        chk("up_0599", {a3, a2, a1, a0}, 16'h0599);
        step(1);
        chk("carry_1000", {a3, a2, a1, a0}, 16'h1000);
        up0 = 1'b0;
        step(1);
        chk("borrow_0599", {a3, a2, a1, a0}, 16'h0599);
        step(1);
        chk("down_0598", {a3, a2, a1, a0}, 16'h0598);
        up0 = 1'b1;
        step(1477);
        chk("up_3275", {a3, a2, a1, a0}, 16'h3275);
        clr0 = 1'b1;
        step(1);
        chk("clr_edge", {a3, a2, a1, a0}, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("clr_held", {a3, a2, a1, a0}, 16'h0000);
        end
        clr0 = 1'b0;
        up0 = 1'b0;
        step(1);
`ifdef ENHANCED_STOPWATCH_WRAP_EN
        chk("down_from_zero", {a3, a2, a1, a0}, 16'h9599);
`else
        chk("down_from_zero", {a3, a2, a1, a0}, 16'h0000);
`endif
        clr0 = 1'b1;
        step(1);
        clr0 = 1'b0;
        up0 = 1'b1;
        step(5999);
        chk("up_max", {a3, a2, a1, a0}, 16'h9599);
        step(1);
`ifdef ENHANCED_STOPWATCH_WRAP_EN
        chk("up_past_max", {a3, a2, a1, a0}, 16'h0000);
        up0 = 1'b0;
        step(1);
        chk("down_wrap", {a3, a2, a1, a0}, 16'h9599);
`else
        chk("up_past_max", {a3, a2, a1, a0}, 16'h9599);
        up0 = 1'b0;
        step(1);
        chk("down_from_max", {a3, a2, a1, a0}, 16'h9598);
`endif
        // Asynchronous reset in the middle of a clock period
        up0 = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {a3, a2, a1, a0}, 16'h0000);
        #1;
        reset_n = 1'b1;
        step(3);
        chk("restart", {a3, a2, a1, a0}, 16'h0003);
        go0 = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
